// File: rtl/lru_access_ctrl.sv
// ---------------------------------------------------------------------------
// lru_access_ctrl
//
// Turns user mode + button/clap events into single req/ack transactions on
// the shared LRU storage datapath. Read data is captured for the display,
// timeouts raise a sticky error flag and triggers that cannot be served
// pulse drop_o.
//
// Optional feature macro: LRU_CTRL_PENDING_EN
//   When defined, one trigger arriving while a transaction is in flight is
//   parked in a pending slot and issued right after the current one ends.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   state_i[2:0]          one-hot mode: 100 CNT_EN, 010 LRU_WR, 001 LRU_RD
//   set_i                 set button level (edge-detected here)
//   clap_i                one-cycle clap pulse (used in CNT_EN only)
//   sw_data_i, sw_idx_i   switch write data / read index
//   cnt_value_i           live counter value (written in CNT_EN)
//   lru_req_o, lru_we_o, lru_addr_o, lru_wdata_o
//                         transaction to LRU, held stable while in REQ
//   lru_ack_i, lru_rdata_i
//                         completion from LRU, rdata valid with ack on reads
//   disp_data_o           last successfully read word
//   busy_o                transaction in flight
//   done_o                one-cycle pulse on successful completion
//   err_o                 sticky timeout flag (cleared by next success)
//   drop_o                one-cycle pulse when a trigger is discarded
//
// Handshake: lru_req_o rises with the operands valid and stays high with
// the operands unchanged until a cycle in which lru_ack_i is sampled high
// (transaction complete) or the timeout expires (transaction abandoned).
// ---------------------------------------------------------------------------
module lru_access_ctrl #(
    parameter int DATA_W  = 8,
    parameter int IDX_W   = 3,
    parameter int TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [2:0]        state_i,
    input  logic              set_i,
    input  logic              clap_i,
    input  logic [DATA_W-1:0] sw_data_i,
    input  logic [IDX_W-1:0]  sw_idx_i,
    input  logic [DATA_W-1:0] cnt_value_i,
    output logic              lru_req_o,
    output logic              lru_we_o,
    output logic [IDX_W-1:0]  lru_addr_o,
    output logic [DATA_W-1:0] lru_wdata_o,
    input  logic              lru_ack_i,
    input  logic [DATA_W-1:0] lru_rdata_i,
    output logic [DATA_W-1:0] disp_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              drop_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    localparam int              CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    // ---------------- registers ----------------
    logic [0:0]        state_q,  state_d;
    logic              set_q;
    logic              req_q,    req_d;
    logic              we_q,     we_d;
    logic [IDX_W-1:0]  addr_q,   addr_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic [DATA_W-1:0] disp_q,   disp_d;
    logic [CNT_W-1:0]  tmo_q,    tmo_d;
    logic              done_q,   done_d;
    logic              err_q,    err_d;
    logic              drop_q,   drop_d;

`ifdef LRU_CTRL_PENDING_EN
    logic              pend_v_q,     pend_v_d;
    logic              pend_we_q,    pend_we_d;
    logic [IDX_W-1:0]  pend_addr_q,  pend_addr_d;
    logic [DATA_W-1:0] pend_wdata_q, pend_wdata_d;
`endif

    // ---------------- trigger decode ----------------
    logic              set_rise;
    logic              mode_cnt, mode_wr, mode_rd;
    logic              trig;
    logic              trig_we;
    logic [IDX_W-1:0]  trig_addr;
    logic [DATA_W-1:0] trig_wdata;

    assign set_rise = set_i & ~set_q;

    // Exact compares: any non-one-hot mode decodes to no mode at all.
    assign mode_cnt = (state_i == 3'b100);
    assign mode_wr  = (state_i == 3'b010);
    assign mode_rd  = (state_i == 3'b001);

    // In CNT_EN a set edge and a clap in the same cycle are one operation.
    assign trig       = ((mode_wr | mode_rd) & set_rise) |
                        (mode_cnt & (set_rise | clap_i));
    assign trig_we    = ~mode_rd;
    assign trig_addr  = mode_rd ? sw_idx_i : '0;
    assign trig_wdata = mode_cnt ? cnt_value_i :
                        (mode_wr ? sw_data_i : '0);

    // ---------------- next state ----------------
    logic finish;
    assign finish = lru_ack_i | (tmo_q == TMO_LAST);

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        disp_d  = disp_q;
        tmo_d   = tmo_q;
        done_d  = 1'b0;
        err_d   = err_q;
        drop_d  = 1'b0;
`ifdef LRU_CTRL_PENDING_EN
        pend_v_d     = pend_v_q;
        pend_we_d    = pend_we_q;
        pend_addr_d  = pend_addr_q;
        pend_wdata_d = pend_wdata_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // Ack while idle has no meaning and is ignored.
                if (trig) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    we_d    = trig_we;
                    addr_d  = trig_addr;
                    wdata_d = trig_wdata;
                    tmo_d   = '0;
                end
            end

            default: begin // ST_REQ
                // Ack takes priority over a timeout on the same cycle.
                if (lru_ack_i) begin
                    done_d = 1'b1;
                    err_d  = 1'b0;
                    if (!we_q) begin
                        disp_d = lru_rdata_i;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d = 1'b1;
                end

`ifdef LRU_CTRL_PENDING_EN
                if (finish) begin
                    if (pend_v_q) begin
                        // Chain straight into the parked op; req stays high.
                        we_d     = pend_we_q;
                        addr_d   = pend_addr_q;
                        wdata_d  = pend_wdata_q;
                        tmo_d    = '0;
                        pend_v_d = 1'b0;
                        if (trig) begin
                            // Slot just freed, so this trigger refills it.
                            pend_v_d     = 1'b1;
                            pend_we_d    = trig_we;
                            pend_addr_d  = trig_addr;
                            pend_wdata_d = trig_wdata;
                        end
                    end else if (trig) begin
                        // Trigger on the finishing cycle with an empty slot
                        // is issued directly rather than lost.
                        we_d    = trig_we;
                        addr_d  = trig_addr;
                        wdata_d = trig_wdata;
                        tmo_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                        req_d   = 1'b0;
                    end
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (trig) begin
                        if (!pend_v_q) begin
                            pend_v_d     = 1'b1;
                            pend_we_d    = trig_we;
                            pend_addr_d  = trig_addr;
                            pend_wdata_d = trig_wdata;
                        end else begin
                            drop_d = 1'b1;
                        end
                    end
                end
`else
                if (finish) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
                // No queueing: anything arriving while in flight is lost.
                if (trig) begin
                    drop_d = 1'b1;
                end
`endif
            end
        endcase
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            set_q   <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            disp_q  <= '0;
            tmo_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            set_q   <= set_i;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            disp_q  <= disp_d;
            tmo_q   <= tmo_d;
            done_q  <= done_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
        end
    end

`ifdef LRU_CTRL_PENDING_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_v_q     <= 1'b0;
            pend_we_q    <= 1'b0;
            pend_addr_q  <= '0;
            pend_wdata_q <= '0;
        end else begin
            pend_v_q     <= pend_v_d;
            pend_we_q    <= pend_we_d;
            pend_addr_q  <= pend_addr_d;
            pend_wdata_q <= pend_wdata_d;
        end
    end
`endif

    // ---------------- outputs ----------------
    assign lru_req_o   = req_q;
    assign lru_we_o    = we_q;
    assign lru_addr_o  = addr_q;
    assign lru_wdata_o = wdata_q;
    assign disp_data_o = disp_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign drop_o      = drop_q;

endmodule

// File: tb/tb_lru_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lru_access_ctrl
//
// Directed bench for lru_access_ctrl with DATA_W=8, IDX_W=3, TIMEOUT=16.
// Inputs change 1 ns after each rising edge; outputs are sampled at that
// same point, when the registered outputs have settled.
// ---------------------------------------------------------------------------
module tb_lru_access_ctrl;

    localparam int DATA_W  = 8;
    localparam int IDX_W   = 3;
    localparam int TIMEOUT = 16;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [2:0]        state_i;
    logic              set_i;
    logic              clap_i;
    logic [DATA_W-1:0] sw_data_i;
    logic [IDX_W-1:0]  sw_idx_i;
    logic [DATA_W-1:0] cnt_value_i;
    logic              lru_req_o;
    logic              lru_we_o;
    logic [IDX_W-1:0]  lru_addr_o;
    logic [DATA_W-1:0] lru_wdata_o;
    logic              lru_ack_i;
    logic [DATA_W-1:0] lru_rdata_i;
    logic [DATA_W-1:0] disp_data_o;
    logic              busy_o;
    logic              done_o;
    logic              err_o;
    logic              drop_o;

    int checks = 0;
    int errors = 0;

    lru_access_ctrl #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .state_i    (state_i),
        .set_i      (set_i),
        .clap_i     (clap_i),
        .sw_data_i  (sw_data_i),
        .sw_idx_i   (sw_idx_i),
        .cnt_value_i(cnt_value_i),
        .lru_req_o  (lru_req_o),
        .lru_we_o   (lru_we_o),
        .lru_addr_o (lru_addr_o),
        .lru_wdata_o(lru_wdata_o),
        .lru_ack_i  (lru_ack_i),
        .lru_rdata_i(lru_rdata_i),
        .disp_data_o(disp_data_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .drop_o     (drop_o)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_i = 1'b1; state_i = 3'b000; set_i = 1'b0; clap_i = 1'b0;
        sw_data_i = '0; sw_idx_i = '0; cnt_value_i = '0;
        lru_ack_i = 1'b0; lru_rdata_i = '0;
        tick(); tick();
        checks++;
        if ({lru_req_o, busy_o, done_o, err_o, drop_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {lru_req_o, busy_o, done_o, err_o, drop_o});
        end
        checks++;
        if (disp_data_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_disp: got %h expected 00", disp_data_o);
        end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_read();
        state_i = 3'b001; sw_idx_i = 3'd5; set_i = 1'b1;
        tick();
        // Mode and index change right after the trigger must not matter.
        set_i = 1'b0; state_i = 3'b100; sw_idx_i = 3'd2;
        checks++;
        if ({lru_req_o, lru_we_o, lru_addr_o, busy_o} !== {1'b1, 1'b0, 3'd5, 1'b1}) begin
            errors++;
            $display("FAIL read_issue: got req=%b we=%b addr=%0d busy=%b expected 1 0 5 1",
                     lru_req_o, lru_we_o, lru_addr_o, busy_o);
        end
        tick();
        checks++;
        if ({lru_req_o, lru_addr_o} !== {1'b1, 3'd5}) begin
            errors++;
            $display("FAIL read_hold: got req=%b addr=%0d expected 1 5", lru_req_o, lru_addr_o);
        end
        lru_ack_i = 1'b1; lru_rdata_i = 8'h3C;
        tick();
        lru_ack_i = 1'b0; lru_rdata_i = 8'h00;
        checks++;
        if ({lru_req_o, done_o, busy_o, disp_data_o} !== {1'b0, 1'b1, 1'b0, 8'h3C}) begin
            errors++;
            $display("FAIL read_done: got req=%b done=%b busy=%b disp=%h expected 0 1 0 3c",
                     lru_req_o, done_o, busy_o, disp_data_o);
        end
        tick();
        checks++;
        if (done_o !== 1'b0) begin
            errors++;
            $display("FAIL read_done_pulse: got %b expected 0", done_o);
        end
    endtask

    task automatic test_write();
        int req_cycles;
        req_cycles = 0;
        state_i = 3'b010; sw_data_i = 8'hA5; set_i = 1'b1;
        tick();
        set_i = 1'b0; sw_data_i = 8'h00;
        checks++;
        if ({lru_req_o, lru_we_o, lru_addr_o, lru_wdata_o} !== {1'b1, 1'b1, 3'd0, 8'hA5}) begin
            errors++;
            $display("FAIL write_issue: got req=%b we=%b addr=%0d wdata=%h expected 1 1 0 a5",
                     lru_req_o, lru_we_o, lru_addr_o, lru_wdata_o);
        end
        // Ack is raised during the third request cycle.
        for (int i = 0; i < 3; i++) begin
            if (lru_req_o === 1'b1 && lru_wdata_o === 8'hA5) req_cycles++;
            if (i == 2) lru_ack_i = 1'b1;
            tick();
        end
        lru_ack_i = 1'b0;
        checks++;
        if (req_cycles !== 3) begin
            errors++;
            $display("FAIL write_req_cycles: got %0d expected 3", req_cycles);
        end
        checks++;
        if ({lru_req_o, done_o, disp_data_o} !== {1'b0, 1'b1, 8'h3C}) begin
            errors++;
            $display("FAIL write_done: got req=%b done=%b disp=%h expected 0 1 3c",
                     lru_req_o, done_o, disp_data_o);
        end
        tick();
    endtask

    task automatic test_cnt_en();
        state_i = 3'b100; cnt_value_i = 8'h17; set_i = 1'b1; clap_i = 1'b1;
        tick();
        set_i = 1'b0; clap_i = 1'b0; cnt_value_i = 8'h99;
        checks++;
        if ({lru_req_o, lru_we_o, lru_wdata_o, drop_o} !== {1'b1, 1'b1, 8'h17, 1'b0}) begin
            errors++;
            $display("FAIL cnt_issue: got req=%b we=%b wdata=%h drop=%b expected 1 1 17 0",
                     lru_req_o, lru_we_o, lru_wdata_o, drop_o);
        end
        lru_ack_i = 1'b1;
        tick();
        lru_ack_i = 1'b0;
        tick(); tick();
        checks++;
        if ({lru_req_o, busy_o} !== 2'b00) begin
            errors++;
            $display("FAIL cnt_single_op: got req=%b busy=%b expected 0 0", lru_req_o, busy_o);
        end
        // Clap alone in LRU_RD and a set edge with a non-one-hot mode do nothing.
        state_i = 3'b001; clap_i = 1'b1;
        tick();
        clap_i = 1'b0; state_i = 3'b110; set_i = 1'b1;
        checks++;
        if (lru_req_o !== 1'b0) begin
            errors++;
            $display("FAIL clap_in_rd: got req=%b expected 0", lru_req_o);
        end
        tick();
        set_i = 1'b0;
        checks++;
        if (lru_req_o !== 1'b0) begin
            errors++;
            $display("FAIL non_onehot: got req=%b expected 0", lru_req_o);
        end
        tick();
    endtask

    task automatic test_timeout();
        int req_cycles;
        bit saw_done;
        req_cycles = 0; saw_done = 1'b0;
        state_i = 3'b010; sw_data_i = 8'h44; set_i = 1'b1;
        tick();
        set_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (lru_req_o !== 1'b1) break;
            req_cycles++;
            tick();
            if (done_o === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (req_cycles !== TIMEOUT) begin
            errors++;
            $display("FAIL timeout_cycles: got %0d expected %0d", req_cycles, TIMEOUT);
        end
        checks++;
        if ({err_o, busy_o, saw_done} !== 3'b100) begin
            errors++;
            $display("FAIL timeout_flags: got err=%b busy=%b done_seen=%b expected 1 0 0",
                     err_o, busy_o, saw_done);
        end
        tick(); tick();
        checks++;
        if (err_o !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got %b expected 1", err_o);
        end
        set_i = 1'b1;
        tick();
        set_i = 1'b0; lru_ack_i = 1'b1;
        tick();
        lru_ack_i = 1'b0;
        checks++;
        if ({done_o, err_o} !== 2'b10) begin
            errors++;
            $display("FAIL err_clear: got done=%b err=%b expected 1 0", done_o, err_o);
        end
        tick();
    endtask

    task automatic test_drop();
        state_i = 3'b010; sw_data_i = 8'h11; set_i = 1'b1;
        tick();
        set_i = 1'b0;
        tick();
        sw_data_i = 8'h22; set_i = 1'b1;
        tick();
        set_i = 1'b0;
`ifdef LRU_CTRL_PENDING_EN
        checks++;
        if ({drop_o, lru_wdata_o} !== {1'b0, 8'h11}) begin
            errors++;
            $display("FAIL pend_capture: got drop=%b wdata=%h expected 0 11", drop_o, lru_wdata_o);
        end
        tick();
        sw_data_i = 8'h33; set_i = 1'b1;
        tick();
        set_i = 1'b0;
        checks++;
        if (drop_o !== 1'b1) begin
            errors++;
            $display("FAIL pend_full_drop: got %b expected 1", drop_o);
        end
        lru_ack_i = 1'b1;
        tick();
        lru_ack_i = 1'b0;
        checks++;
        if ({lru_req_o, done_o, lru_wdata_o} !== {1'b1, 1'b1, 8'h22}) begin
            errors++;
            $display("FAIL pend_issue: got req=%b done=%b wdata=%h expected 1 1 22",
                     lru_req_o, done_o, lru_wdata_o);
        end
        lru_ack_i = 1'b1;
        tick();
        lru_ack_i = 1'b0;
        tick();
        checks++;
        if (lru_req_o !== 1'b0) begin
            errors++;
            $display("FAIL pend_empty: got req=%b expected 0", lru_req_o);
        end
`else
        checks++;
        if ({drop_o, lru_req_o, lru_wdata_o} !== {1'b1, 1'b1, 8'h11}) begin
            errors++;
            $display("FAIL drop_pulse: got drop=%b req=%b wdata=%h expected 1 1 11",
                     drop_o, lru_req_o, lru_wdata_o);
        end
        tick();
        checks++;
        if (drop_o !== 1'b0) begin
            errors++;
            $display("FAIL drop_one_cycle: got %b expected 0", drop_o);
        end
        lru_ack_i = 1'b1;
        tick();
        lru_ack_i = 1'b0;
        tick();
        checks++;
        if (lru_req_o !== 1'b0) begin
            errors++;
            $display("FAIL drop_no_second_op: got req=%b expected 0", lru_req_o);
        end
`endif
        tick();
    endtask

    task automatic test_back_to_back();
        state_i = 3'b010; sw_data_i = 8'h5A; set_i = 1'b1;
        tick();
        set_i = 1'b0; lru_ack_i = 1'b1;
        tick();
        lru_ack_i = 1'b0;
        // This is the single idle cycle; trigger again right here.
        sw_data_i = 8'h6B; set_i = 1'b1;
        checks++;
        if ({lru_req_o, done_o} !== 2'b01) begin
            errors++;
            $display("FAIL b2b_gap: got req=%b done=%b expected 0 1", lru_req_o, done_o);
        end
        tick();
        set_i = 1'b0;
        checks++;
        if ({lru_req_o, lru_wdata_o} !== {1'b1, 8'h6B}) begin
            errors++;
            $display("FAIL b2b_second: got req=%b wdata=%h expected 1 6b", lru_req_o, lru_wdata_o);
        end
        lru_ack_i = 1'b1;
        tick();
        lru_ack_i = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        state_i = 3'b010; sw_data_i = 8'h77; set_i = 1'b1;
        tick();
        set_i = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        checks++;
        if ({lru_req_o, busy_o, disp_data_o} !== {1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL async_reset: got req=%b busy=%b disp=%h expected 0 0 00",
                     lru_req_o, busy_o, disp_data_o);
        end
        #2 rst_i = 1'b0;
        lru_ack_i = 1'b1;
        tick();
        lru_ack_i = 1'b0;
        tick();
        checks++;
        if ({done_o, lru_req_o, busy_o} !== 3'b000) begin
            errors++;
            $display("FAIL post_reset_no_done: got done=%b req=%b busy=%b expected 0 0 0",
                     done_o, lru_req_o, busy_o);
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        test_reset();
        test_read();
        test_write();
        test_cnt_en();
        test_timeout();
        test_drop();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
